// File: rtl/axis_stream_source.sv
// AXI-Stream master stimulus source: LFSR or counter payload, programmable
// (optionally pseudo-random) inter-beat gaps and an optional beat limit.
module axis_stream_source #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MODE       = 0,
    parameter logic [31:0] SEED       = 32'h0000_0001,
    parameter int unsigned GAP_MIN    = 0,
    parameter logic [7:0]  GAP_MASK   = 8'h00,
    parameter int unsigned COUNT      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  m_axis_ready,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic [15:0]           beat_count,
    output logic                  done
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] TAPS     = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                state_q, state_d;
    logic [31:0]           lfsr_q, lfsr_d, lfsr_nxt;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [8:0]            gap_q, gap_d, gap_val;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [15:0]           beat_q, beat_d;
    logic                  done_q, done_d;
    logic [31:0]           sent_q, sent_d;
    logic [DATA_WIDTH-1:0] cur_load, nxt_load;
    logic                  handshake, last_beat;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // The gap after a beat is drawn from the already-stepped LFSR.
    assign lfsr_nxt  = lfsr_step(lfsr_q);
    assign cnt_nxt   = cnt_q + DATA_WIDTH'(1);
    assign gap_val   = 9'(GAP_MIN) + {1'b0, lfsr_nxt[31:24] & GAP_MASK};
    assign cur_load  = (MODE == 0) ? lfsr_q[DATA_WIDTH-1:0] : cnt_q;
    assign nxt_load  = (MODE == 0) ? lfsr_nxt[DATA_WIDTH-1:0] : cnt_nxt;
    assign handshake = valid_q & m_axis_ready;
    assign last_beat = (COUNT != 0) && ((sent_q + 32'd1) == 32'(COUNT));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        valid_d = valid_q;
        data_d  = data_q;
        beat_d  = beat_q;
        done_d  = done_q;
        sent_d  = sent_q;

        case (state_q)
            IDLE: begin
                if (en && !done_q) begin
                    data_d  = cur_load;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    beat_d = (beat_q == 16'hFFFF) ? beat_q : beat_q + 16'd1;
                    lfsr_d = lfsr_nxt;
                    cnt_d  = cnt_nxt;
                    sent_d = sent_q + 32'd1;
                    if (last_beat) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (gap_val == 9'd0) begin
                        if (en) begin
                            data_d = nxt_load;
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        valid_d = 1'b0;
                        gap_d   = gap_val;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - 9'd1;
                if (gap_q <= 9'd1) begin
                    gap_d = 9'd0;
                    if (en) begin
                        data_d  = cur_load;
                        valid_d = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            cnt_q   <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
            sent_q  <= sent_d;
        end
    end

    assign m_axis_valid = valid_q;
    assign m_axis_data  = data_q;
    assign beat_count   = beat_q;
    assign done         = done_q;

endmodule

// File: tb/tb_axis_stream_source.sv
// Self-checking bench for axis_stream_source: vector table, directed corner
// sequences and a randomized run against a rule-based reference model.
module tb_axis_stream_source;

    localparam int unsigned R_GAP_MIN  = 1;
    localparam logic [7:0]  R_GAP_MASK = 8'h03;
    localparam logic [31:0] R_SEED     = 32'hACE1_2345;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, ready;
    logic v1, v2, v3, v4, v5;
    logic [7:0] d1, d2, d3, d4;
    logic [11:0] d5;
    logic [15:0] b1, b2, b3, b4, b5;
    logic dn1, dn2, dn3, dn4, dn5;

    axis_stream_source #(.DATA_WIDTH(8), .MODE(1)) u_cnt (
        .clk(clk), .rst(rst), .en(en), .m_axis_ready(ready),
        .m_axis_valid(v1), .m_axis_data(d1), .beat_count(b1), .done(dn1));

    axis_stream_source #(.DATA_WIDTH(8), .MODE(1), .GAP_MIN(3)) u_gap (
        .clk(clk), .rst(rst), .en(en), .m_axis_ready(ready),
        .m_axis_valid(v2), .m_axis_data(d2), .beat_count(b2), .done(dn2));

    axis_stream_source #(.DATA_WIDTH(8), .MODE(0), .SEED(32'h1)) u_lfsr (
        .clk(clk), .rst(rst), .en(en), .m_axis_ready(ready),
        .m_axis_valid(v3), .m_axis_data(d3), .beat_count(b3), .done(dn3));

    axis_stream_source #(.DATA_WIDTH(8), .MODE(1), .COUNT(4)) u_lim (
        .clk(clk), .rst(rst), .en(en), .m_axis_ready(ready),
        .m_axis_valid(v4), .m_axis_data(d4), .beat_count(b4), .done(dn4));

    axis_stream_source #(.DATA_WIDTH(12), .MODE(0), .SEED(R_SEED),
                         .GAP_MIN(R_GAP_MIN), .GAP_MASK(R_GAP_MASK)) u_rnd (
        .clk(clk), .rst(rst), .en(en), .m_axis_ready(ready),
        .m_axis_valid(v5), .m_axis_data(d5), .beat_count(b5), .done(dn5));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; ready = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    typedef struct {
        logic        rst, en, ready;
        logic        valid;
        logic [7:0]  data;
        logic [15:0] beats;
    } vec_t;

    vec_t vt[18];

    initial begin
        logic [7:0]  seq3 [5];
        logic [31:0] m_lfsr;
        int          m_beats, idle_t, gap;
        logic        pv, pen, prdy, exp_v;

        rst = 1'b1; en = 1'b0; ready = 1'b0;
        @(negedge clk);
        do_reset;

        check("reset_valid", {27'd0, v1, v2, v3, v4, v5}, 32'd0);
        check("reset_data", {d1, d2, d3, d4}, 32'd0);
        check("reset_data_w12", {20'd0, d5}, 32'd0);
        check("reset_beats", {b1 | b2 | b3 | b4, b5}, 32'd0);
        check("reset_done", {27'd0, dn1, dn2, dn3, dn4, dn5}, 32'd0);

        // counter mode, no gaps: start-up, stall, en drop, restart, reset mid-stall
        vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 16'd0};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 16'd1};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 16'd2};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 16'd3};
        for (int i = 4; i <= 8; i++) vt[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd3, 16'd3};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 16'd4};
        vt[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 16'd5};
        vt[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 16'd5};
        vt[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd5, 16'd5};
        vt[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd6, 16'd6};
        vt[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd6, 16'd6};
        vt[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 16'd0};
        vt[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 16'd0};
        vt[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 16'd1};

        for (int i = 0; i < 18; i++) begin
            rst = vt[i].rst; en = vt[i].en; ready = vt[i].ready;
            tick;
            check($sformatf("vec%0d_valid", i), {31'd0, v1}, {31'd0, vt[i].valid});
            check($sformatf("vec%0d_beats", i), {16'd0, b1}, {16'd0, vt[i].beats});
            if (vt[i].valid) check($sformatf("vec%0d_data", i), {24'd0, d1}, {24'd0, vt[i].data});
        end
        rst = 1'b0;

        // continuous streaming through the 255 -> 0 wrap
        en = 1'b1; ready = 1'b1;
        for (int k = 1; k <= 270; k++) begin
            tick;
            check($sformatf("wrap%0d_data", k), {24'd0, d1}, 32'((1 + k) % 256));
            check($sformatf("wrap%0d_beats", k), {16'd0, b1}, 32'(1 + k));
        end

        // fixed gap of 3 idle cycles
        do_reset;
        en = 1'b1; ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick;
            check($sformatf("gap%0d_valid", k), {31'd0, v2}, {31'd0, (k % 4) == 0});
            if ((k % 4) == 0) check($sformatf("gap%0d_data", k), {24'd0, d2}, 32'(k / 4));
        end

        // LFSR data with SEED=1
        seq3[0] = 8'h01; seq3[1] = 8'h03; seq3[2] = 8'h02; seq3[3] = 8'h01; seq3[4] = 8'h03;
        do_reset;
        en = 1'b1; ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            check($sformatf("lfsr%0d_valid", k), {31'd0, v3}, 32'd1);
            check($sformatf("lfsr%0d_data", k), {24'd0, d3}, {24'd0, seq3[k]});
        end

        // beat limit of 4
        do_reset;
        en = 1'b1; ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            check($sformatf("lim%0d_data", k), {24'd0, d4}, 32'(k));
            check($sformatf("lim%0d_done", k), {31'd0, dn4}, 32'd0);
        end
        for (int k = 0; k < 11; k++) begin
            tick;
            check($sformatf("lim_end%0d", k), {15'd0, v4, b4}, {15'd0, 1'b0, 16'd4});
            check($sformatf("lim_done%0d", k), {31'd0, dn4}, 32'd1);
        end

        // randomized en/ready against a rule-based model:
        // beat k carries the LFSR after k steps; after a beat, valid returns at
        // the first edge at least 'gap' edges later on which en is high.
        do_reset;
        m_lfsr = R_SEED; m_beats = 0; idle_t = 0; gap = 0; pv = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            en    = ($urandom_range(0, 9) != 0);
            ready = ($urandom_range(0, 2) != 0);
            pen = en; prdy = ready;
            tick;
            if (pv && prdy) begin
                m_beats++;
                m_lfsr = lfsr_next(m_lfsr);
                gap    = int'(R_GAP_MIN) + int'(m_lfsr[31:24] & R_GAP_MASK);
                idle_t = 0;
                exp_v  = 1'b0;
            end else if (pv) begin
                exp_v = 1'b1;
            end else begin
                idle_t++;
                exp_v = (idle_t >= gap) && pen;
            end
            check($sformatf("rnd%0d_valid", c), {31'd0, v5}, {31'd0, exp_v});
            check($sformatf("rnd%0d_beats", c), {16'd0, b5}, 32'(m_beats));
            if (exp_v) check($sformatf("rnd%0d_data", c), {20'd0, d5}, {20'd0, m_lfsr[11:0]});
            pv = exp_v;
        end
        check("rnd_done_low", {31'd0, dn5}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
